// File: rtl/uart_rx.sv
// uart_rx - oversampling UART receiver with a one-entry output register.
//
// Hunts for a falling edge on the synchronised serial line and confirms the
// start bit at its midpoint. It then samples each data bit at the centre of
// its bit period, LSB first, and checks the stop bit. Completed bytes are
// handed to the consumer through a valid/ready register that holds one byte.
//
// Parameters
//   DATA_BITS   data bits per frame (at least 2)
//   OVERSAMPLE  baud_tick pulses per bit period (even, at least 4)
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   baud_tick    in   single-cycle oversample strobe
//   rx_i         in   asynchronous serial line, idle high
//   rx_data      out  received byte, valid while rx_valid=1
//   rx_valid     out  byte available, held until accepted
//   rx_ready     in   consumer accepts rx_data when rx_valid=1
//   frame_err    out  one-cycle pulse, stop bit sampled low
//   overrun_err  out  one-cycle pulse, completed byte dropped (register full)

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 baud_tick,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  rx_meta;
  logic                  rx_s;

  logic                  stop_sample;
  logic                  frame_done;
  logic                  frame_bad;

  // Two-flop synchroniser. Both flops reset to the idle (high) level so that
  // leaving reset never looks like a falling edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // The stop bit is judged at the centre of its bit period; this is the
  // only point where a frame either completes or is rejected.
  assign stop_sample = baud_tick && (state == STOP) && (tick_cnt == TICK_LAST);
  assign frame_done  = stop_sample && rx_s;
  assign frame_bad   = stop_sample && !rx_s;

  // Receive state machine and output register. The counters and the state
  // move only on baud_tick. The output handshake is evaluated on every clock
  // so the consumer never waits for the baud generator.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_bad;
      overrun_err <= 1'b0;

      // A byte arriving while the consumer takes the old one replaces it
      // seamlessly. Only a full, unaccepted register causes an overrun.
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end

          // Re-check the line half a bit after the edge. A line that is
          // high again was a glitch and is dropped without an error.
          START: begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          // Start-bit centre plus a whole bit period lands on each data
          // bit's centre. Shifting right puts the first (LSB) bit at bit 0.
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
